// File: rtl/pipe_scoreboard.sv
// Register-dependency scoreboard for an in-order pipeline: selects the forwarding source per
// operand and raises a load-use stall when the youngest producer is a load not yet available.
module pipe_scoreboard #(
  parameter int unsigned NREG     = 8,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LD_AVAIL = 1,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned RW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic          issue_wr,
  input  logic          issue_ld,
  input  logic [RW-1:0] issue_rd,
  input  logic [RW-1:0] issue_rs1,
  input  logic [RW-1:0] issue_rs2,
  input  logic          rs1_used,
  input  logic          rs2_used,
  input  logic          flush,
  output logic [2:0]    fwd_rs1,
  output logic [2:0]    fwd_rs2,
  output logic          stall,
  output logic [15:0]   stall_cnt,
  output logic          busy
);

  logic [DEPTH-1:0] valid_q, wr_q, ld_q;
  logic [RW-1:0]    rd_q [DEPTH];
  logic [15:0]      stall_cnt_q;

  logic [2:0] sel1, sel2;
  logic       hazard1, hazard2;
  logic       load_en;

  // Scan oldest to youngest so the youngest matching producer is the one left selected.
  always_comb begin
    sel1    = '0;
    sel2    = '0;
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs1_used && valid_q[k] && wr_q[k] && (rd_q[k] == issue_rs1) &&
          !(ZERO_REG && (issue_rs1 == '0))) begin
        sel1    = 3'(k + 1);
        hazard1 = ld_q[k] && (k < int'(LD_AVAIL));
      end
      if (rs2_used && valid_q[k] && wr_q[k] && (rd_q[k] == issue_rs2) &&
          !(ZERO_REG && (issue_rs2 == '0))) begin
        sel2    = 3'(k + 1);
        hazard2 = ld_q[k] && (k < int'(LD_AVAIL));
      end
    end
  end

  always_comb begin
    fwd_rs1   = issue_valid ? sel1 : 3'd0;
    fwd_rs2   = issue_valid ? sel2 : 3'd0;
    stall     = issue_valid && !flush && (hazard1 || hazard2);
    busy      = |(valid_q & wr_q);
    load_en   = issue_valid && !stall && !flush;
    stall_cnt = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      // Entries keep flowing regardless of stall or flush; only entry 0 takes a bubble.
      valid_q <= {valid_q[DEPTH-2:0], load_en};
      wr_q    <= {wr_q[DEPTH-2:0], load_en && issue_wr};
      ld_q    <= {ld_q[DEPTH-2:0], load_en && issue_ld};
      rd_q[0] <= issue_rd;
      for (int k = 1; k < DEPTH; k++) begin
        rd_q[k] <= rd_q[k-1];
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: default, ZERO_REG=1, DEPTH=5/LD_AVAIL=3 and a
// DEPTH=6/LD_AVAIL=5 instance that is kept stalling to reach counter saturation.
module tb_pipe_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic       rst = 1'b1;
  logic       iv = 1'b0, iw = 1'b0, il = 1'b0, u1 = 1'b0, u2 = 1'b0, fl = 1'b0;
  logic [2:0] ird = '0, irs1 = '0, irs2 = '0;
  logic [2:0] f1, f2;
  logic       st, bz;
  logic [15:0] sc;

  logic [2:0] zf1, zf2;
  logic       zst, zbz;
  logic [15:0] zsc;

  logic       iv5 = 1'b0, iw5 = 1'b0, il5 = 1'b0, u15 = 1'b0;
  logic [2:0] ird5 = '0, irs15 = '0;
  logic [2:0] f15, f25;
  logic       st5, bz5;
  logic [15:0] sc5;

  logic       rst_s = 1'b1;
  logic [2:0] sf1, sf2;
  logic       sst, sbz;
  logic [15:0] ssc;

  pipe_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_wr(iw), .issue_ld(il), .issue_rd(ird),
    .issue_rs1(irs1), .issue_rs2(irs2), .rs1_used(u1), .rs2_used(u2), .flush(fl),
    .fwd_rs1(f1), .fwd_rs2(f2), .stall(st), .stall_cnt(sc), .busy(bz)
  );

  pipe_scoreboard #(.ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_wr(iw), .issue_ld(il), .issue_rd(ird),
    .issue_rs1(irs1), .issue_rs2(irs2), .rs1_used(u1), .rs2_used(u2), .flush(fl),
    .fwd_rs1(zf1), .fwd_rs2(zf2), .stall(zst), .stall_cnt(zsc), .busy(zbz)
  );

  pipe_scoreboard #(.DEPTH(5), .LD_AVAIL(3)) dut5 (
    .clk(clk), .rst(rst), .issue_valid(iv5), .issue_wr(iw5), .issue_ld(il5), .issue_rd(ird5),
    .issue_rs1(irs15), .issue_rs2(3'd0), .rs1_used(u15), .rs2_used(1'b0), .flush(1'b0),
    .fwd_rs1(f15), .fwd_rs2(f25), .stall(st5), .stall_cnt(sc5), .busy(bz5)
  );

  // Self-dependent load held in ID forever: stalls 5 of every 6 cycles.
  pipe_scoreboard #(.DEPTH(6), .LD_AVAIL(5)) dut_s (
    .clk(clk), .rst(rst_s), .issue_valid(1'b1), .issue_wr(1'b1), .issue_ld(1'b1),
    .issue_rd(3'd1), .issue_rs1(3'd1), .issue_rs2(3'd0), .rs1_used(1'b1), .rs2_used(1'b0),
    .flush(1'b0), .fwd_rs1(sf1), .fwd_rs2(sf2), .stall(sst), .stall_cnt(ssc), .busy(sbz)
  );

  task automatic drive(input logic v, w, l, input logic [2:0] rd, r1, r2,
                       input logic a1, a2, f);
    @(negedge clk);
    iv = v; iw = w; il = l; ird = rd; irs1 = r1; irs2 = r2; u1 = a1; u2 = a2; fl = f;
    #1;
  endtask

  task automatic drive5(input logic v, w, l, input logic [2:0] rd, r1, input logic a1);
    @(negedge clk);
    iv5 = v; iw5 = w; il5 = l; ird5 = rd; irs15 = r1; u15 = a1;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    iv = 0; iw = 0; il = 0; u1 = 0; u2 = 0; fl = 0;
    iv5 = 0; iw5 = 0; il5 = 0; u15 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    iv = 1; iw = 1; il = 0; ird = 3'd1; irs1 = 3'd0; u1 = 0; u2 = 0; fl = 0;
    @(negedge clk);
    rst = 1'b0;
    iv = 1; iw = 0; irs1 = 3'd1; u1 = 1;
    #1;
    n_chk++; if (bz !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bz); else n_pass++;
    n_chk++; if (sc !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", sc); else n_pass++;
    n_chk++; if (f1 !== 3'd0) $display("FAIL rst_fwd1: got %0d want 0", f1); else n_pass++;
    n_chk++; if (st !== 1'b0) $display("FAIL rst_stall: got %0b want 0", st); else n_pass++;
    n_chk++; if (bz5 !== 1'b0) $display("FAIL rst_busy5: got %0b want 0", bz5); else n_pass++;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    drive(1, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0);
    drive(1, 0, 0, 3'd5, 3'd0, 3'd0, 1, 0, 0);
    n_chk++; if (f1 !== 3'd1) $display("FAIL b2b_fwd1: got %0d want 1", f1); else n_pass++;
    n_chk++; if (st !== 1'b0) $display("FAIL b2b_stall: got %0b want 0", st); else n_pass++;
    n_chk++; if (bz !== 1'b1) $display("FAIL b2b_busy: got %0b want 1", bz); else n_pass++;
    n_chk++; if (zf1 !== 3'd0) $display("FAIL zero_fwd1: got %0d want 0", zf1); else n_pass++;
    drive(1, 0, 0, 3'd5, 3'd0, 3'd0, 1, 0, 0);
    n_chk++; if (f1 !== 3'd2) $display("FAIL b2b_fwd1_mem: got %0d want 2", f1); else n_pass++;
    n_chk++; if (zf1 !== 3'd0) $display("FAIL zero_fwd1_mem: got %0d want 0", zf1); else n_pass++;
  endtask

  task automatic test_load_use();
    reset_dut();
    drive(1, 1, 1, 3'd2, 3'd0, 3'd0, 0, 0, 0);
    drive(1, 1, 0, 3'd3, 3'd2, 3'd1, 1, 1, 0);
    n_chk++; if (st !== 1'b1) $display("FAIL lu_stall: got %0b want 1", st); else n_pass++;
    n_chk++; if (f1 !== 3'd1) $display("FAIL lu_fwd1_stall: got %0d want 1", f1); else n_pass++;
    n_chk++; if (f2 !== 3'd0) $display("FAIL lu_fwd2: got %0d want 0", f2); else n_pass++;
    drive(1, 1, 0, 3'd3, 3'd2, 3'd1, 1, 1, 0);
    n_chk++; if (st !== 1'b0) $display("FAIL lu_stall_end: got %0b want 0", st); else n_pass++;
    n_chk++; if (f1 !== 3'd2) $display("FAIL lu_fwd1: got %0d want 2", f1); else n_pass++;
    drive(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0);
    n_chk++; if (sc !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", sc); else n_pass++;
  endtask

  task automatic test_youngest();
    reset_dut();
    drive(1, 1, 0, 3'd3, 3'd0, 3'd0, 0, 0, 0);
    drive(1, 1, 0, 3'd3, 3'd0, 3'd0, 0, 0, 0);
    drive(1, 1, 0, 3'd3, 3'd3, 3'd3, 1, 1, 0);
    n_chk++; if (f2 !== 3'd1) $display("FAIL young_fwd2: got %0d want 1", f2); else n_pass++;
    n_chk++; if (f1 !== 3'd1) $display("FAIL young_fwd1: got %0d want 1", f1); else n_pass++;
    u2 = 1'b0;
    #1;
    n_chk++; if (f2 !== 3'd0) $display("FAIL unused_fwd2: got %0d want 0", f2); else n_pass++;
    iv = 1'b0;
    #1;
    n_chk++; if (f1 !== 3'd0) $display("FAIL novalid_fwd1: got %0d want 0", f1); else n_pass++;
  endtask

  task automatic test_flush();
    reset_dut();
    drive(1, 1, 1, 3'd2, 3'd0, 3'd0, 0, 0, 0);
    drive(1, 1, 0, 3'd4, 3'd2, 3'd0, 1, 0, 0);
    n_chk++; if (st !== 1'b1) $display("FAIL fl_pre_stall: got %0b want 1", st); else n_pass++;
    fl = 1'b1;
    #1;
    n_chk++; if (st !== 1'b0) $display("FAIL fl_stall: got %0b want 0", st); else n_pass++;
    drive(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0);
    n_chk++; if (bz !== 1'b1) $display("FAIL fl_busy1: got %0b want 1", bz); else n_pass++;
    drive(1, 0, 0, 3'd0, 3'd4, 3'd0, 1, 0, 0);
    n_chk++; if (f1 !== 3'd0) $display("FAIL fl_bubble: got %0d want 0", f1); else n_pass++;
    drive(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0);
    n_chk++; if (bz !== 1'b0) $display("FAIL fl_busy_clr: got %0b want 0", bz); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    drive(1, 1, 1, 3'd2, 3'd0, 3'd0, 0, 0, 0);
    drive(1, 1, 0, 3'd4, 3'd2, 3'd0, 1, 0, 0);
    n_chk++; if (st !== 1'b1) $display("FAIL rs_pre_stall: got %0b want 1", st); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (st !== 1'b0) $display("FAIL rs_stall: got %0b want 0", st); else n_pass++;
    n_chk++; if (f1 !== 3'd0) $display("FAIL rs_fwd1: got %0d want 0", f1); else n_pass++;
    n_chk++; if (bz !== 1'b0) $display("FAIL rs_busy: got %0b want 0", bz); else n_pass++;
  endtask

  task automatic test_depth5();
    reset_dut();
    drive5(1, 1, 1, 3'd1, 3'd0, 0);
    for (int c = 0; c < 3; c++) begin
      drive5(1, 1, 0, 3'd2, 3'd1, 1);
      n_chk++;
      if (st5 !== 1'b1 || f15 !== 3'(c + 1))
        $display("FAIL d5_stall%0d: got stall=%0b fwd=%0d want stall=1 fwd=%0d", c, st5, f15, c + 1);
      else n_pass++;
    end
    drive5(1, 1, 0, 3'd2, 3'd1, 1);
    n_chk++; if (st5 !== 1'b0) $display("FAIL d5_release: got %0b want 0", st5); else n_pass++;
    n_chk++; if (f15 !== 3'd4) $display("FAIL d5_fwd: got %0d want 4", f15); else n_pass++;
    drive5(0, 0, 0, 3'd0, 3'd0, 0);
    n_chk++; if (sc5 !== 16'd3) $display("FAIL d5_cnt: got %0d want 3", sc5); else n_pass++;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst_s = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    n_chk++; if (ssc !== 16'd500) $display("FAIL sat_partial: got %0d want 500", ssc); else n_pass++;
    repeat (78060) @(posedge clk);
    #1;
    n_chk++; if (ssc !== 16'hFFFF) $display("FAIL sat_full: got %0h want ffff", ssc); else n_pass++;
    repeat (7) @(posedge clk);
    #1;
    n_chk++; if (ssc !== 16'hFFFF) $display("FAIL sat_hold: got %0h want ffff", ssc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_flush();
    test_reset_mid_stall();
    test_depth5();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
